// File: rtl/traffic_light_controller_n.sv
// N-road traffic light controller: green/yellow/all-red cycle with empty-road skipping and emergency/jam preemption.
// Optional pedestrian walk phase is enabled by defining TLC_PED_WALK_EN.
module traffic_light_controller_n #(
    parameter int NUM_ROADS    = 4,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 1,
`ifdef TLC_PED_WALK_EN
    parameter int PED_TICKS    = 10,
`endif
    parameter int CNT_W        = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_ROADS-1:0]         emergency,
    input  logic [NUM_ROADS-1:0]         jam,
    input  logic [NUM_ROADS-1:0]         empty,
`ifdef TLC_PED_WALK_EN
    input  logic                         ped_req,
    output logic                         walk,
`endif
    output logic [3*NUM_ROADS-1:0]       lights,
    output logic [$clog2(NUM_ROADS)-1:0] active_road,
    output logic [1:0]                   phase
);

    localparam int RW = $clog2(NUM_ROADS);

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'((ALLRED_TICKS > 0) ? ALLRED_TICKS - 1 : 0);
`ifdef TLC_PED_WALK_EN
    localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_TICKS - 1);
`endif

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10,
        PH_PED    = 2'b11
    } phase_t;

    phase_t                  phase_reg, phase_next;
    logic [RW-1:0]           active_reg, active_next;
    logic [RW-1:0]           next_reg, next_next;
    logic [CNT_W-1:0]        count_reg, count_next;
    logic                    run_reg;
    logic [3*NUM_ROADS-1:0]  lights_reg;
    wire  [3*NUM_ROADS-1:0]  lights_next;
`ifdef TLC_PED_WALK_EN
    logic                    pending_reg, pending_next;
    logic                    walk_reg;
    logic [RW-1:0]           emg_any_idx;
`endif

    logic [NUM_ROADS-1:0]    active_mask;
    logic [NUM_ROADS-1:0]    emg_other, jam_other, live_other;
    logic [RW-1:0]           emg_idx, jam_idx, rr_idx, rr_pos;
    logic                    rr_found;
    logic                    clear_done;
    logic [CNT_W-1:0]        count_inc;
    int                      rr_sum;

    assign active_mask = {{(NUM_ROADS-1){1'b0}}, 1'b1} << active_reg;
    assign emg_other   = emergency & ~active_mask;
    assign jam_other   = jam & ~active_mask;
    assign live_other  = ~empty & ~active_mask;
    assign count_inc   = (&count_reg) ? count_reg : count_reg + CNT_W'(1);

    // Lowest-index priority encoders plus the round-robin successor of the active road.
    always_comb begin
        emg_idx  = '0;
        jam_idx  = '0;
        rr_idx   = '0;
        rr_pos   = '0;
        rr_found = 1'b0;
        rr_sum   = 0;
`ifdef TLC_PED_WALK_EN
        emg_any_idx = '0;
`endif
        for (int i = NUM_ROADS - 1; i >= 0; i--) begin
            if (emg_other[i]) emg_idx = RW'(i);
            if (jam_other[i]) jam_idx = RW'(i);
`ifdef TLC_PED_WALK_EN
            if (emergency[i]) emg_any_idx = RW'(i);
`endif
        end
        for (int k = NUM_ROADS - 1; k >= 1; k--) begin
            rr_sum = int'(active_reg) + k;
            if (rr_sum >= NUM_ROADS) rr_sum = rr_sum - NUM_ROADS;
            rr_pos = RW'(rr_sum);
            if (!empty[rr_pos]) begin
                rr_found = 1'b1;
                rr_idx   = rr_pos;
            end
        end
    end

    always_comb begin
        phase_next  = phase_reg;
        active_next = active_reg;
        next_next   = next_reg;
        count_next  = count_reg;
        clear_done  = 1'b0;
`ifdef TLC_PED_WALK_EN
        pending_next = pending_reg | ped_req;
`endif
        if (run_reg) begin
            case (phase_reg)
                PH_GREEN: begin
                    if (emergency[active_reg]) begin
                        // Held green keeps the count at zero so a full green follows release.
                        count_next = '0;
                    end else if (|emg_other) begin
                        phase_next = PH_YELLOW;
                        next_next  = emg_idx;
                        count_next = '0;
                    end else if (|jam_other) begin
                        phase_next = PH_YELLOW;
                        next_next  = jam_idx;
                        count_next = '0;
                    end else if (empty[active_reg] && (|live_other)) begin
                        phase_next = PH_YELLOW;
                        next_next  = rr_idx;
                        count_next = '0;
                    end else if (count_reg == GREEN_LAST) begin
                        count_next = '0;
                        if (rr_found) begin
                            phase_next = PH_YELLOW;
                            next_next  = rr_idx;
                        end
                    end else begin
                        count_next = count_inc;
                    end
                end
                PH_YELLOW: begin
                    if ((|emg_other) && !emergency[next_reg]) next_next = emg_idx;
                    if (count_reg == YELLOW_LAST) begin
                        count_next = '0;
                        if (ALLRED_TICKS > 0) phase_next = PH_ALLRED;
                        else clear_done = 1'b1;
                    end else begin
                        count_next = count_inc;
                    end
                end
                PH_ALLRED: begin
                    if ((|emg_other) && !emergency[next_reg]) next_next = emg_idx;
                    if (count_reg == ALLRED_LAST) clear_done = 1'b1;
                    else count_next = count_inc;
                end
`ifdef TLC_PED_WALK_EN
                PH_PED: begin
                    if (|emergency) begin
                        phase_next  = PH_GREEN;
                        active_next = emg_any_idx;
                        count_next  = '0;
                    end else if (count_reg == PED_LAST) begin
                        phase_next  = PH_GREEN;
                        active_next = next_reg;
                        count_next  = '0;
                    end else begin
                        count_next = count_inc;
                    end
                end
`endif
                default: phase_next = PH_GREEN;
            endcase

            // Leaving the clearance interval: serve the next road, or the walk phase if one is pending.
            if (clear_done) begin
                count_next = '0;
`ifdef TLC_PED_WALK_EN
                if (pending_reg) begin
                    phase_next   = PH_PED;
                    pending_next = 1'b0;
                end else begin
                    phase_next  = PH_GREEN;
                    active_next = next_next;
                end
`else
                phase_next  = PH_GREEN;
                active_next = next_next;
`endif
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_ROADS; gi++) begin : g_lamp
            localparam logic [RW-1:0] IDX = RW'(gi);
            assign lights_next[3*gi +: 3] =
                (phase_next == PH_GREEN  && active_next == IDX) ? 3'b001 :
                (phase_next == PH_YELLOW && active_next == IDX) ? 3'b010 :
                (phase_next == PH_YELLOW && next_next   == IDX) ? 3'b110 :
                                                                  3'b100;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_reg   <= PH_GREEN;
            active_reg  <= '0;
            next_reg    <= RW'(1);
            count_reg   <= '0;
            run_reg     <= 1'b0;
            lights_reg  <= '0;
`ifdef TLC_PED_WALK_EN
            pending_reg <= 1'b0;
            walk_reg    <= 1'b0;
`endif
        end else begin
            phase_reg   <= phase_next;
            active_reg  <= active_next;
            next_reg    <= next_next;
            count_reg   <= count_next;
            run_reg     <= 1'b1;
            lights_reg  <= lights_next;
`ifdef TLC_PED_WALK_EN
            pending_reg <= pending_next;
            walk_reg    <= (phase_next == PH_PED);
`endif
        end
    end

    assign lights      = lights_reg;
    assign active_road = active_reg;
    assign phase       = phase_reg;
`ifdef TLC_PED_WALK_EN
    assign walk        = walk_reg;
`endif

endmodule
